nand_io_burst_unit: RTL
=======================

# nand_io_burst_unit

Parametrised successor to the single-word NAND data IO unit: moves a burst of 1..2^LEN_W−1 words between the controller datapath and the NAND DQ bus per activation, generating the WE#/RE# strobe with per-phase timing taken from parameters. Write data enters through a valid/ready handshake and read data leaves as one-cycle valid pulses. The block sits between the command/sequencer FSM and the DQ pad ring, and adds burst length, configurable bus width, explicit output-enable and abort support.

## Interface
- DW, 8: DQ/data width (8 or 16).
- LEN_W, 16: width of burst-length input.
- T_WP, 3: WE# low cycles per write word (≥1).
- T_WH, 2: WE# high cycles after each write word (≥1).
- T_REA, 4: RE# low cycles per read word (≥1).
- T_REH, 2: RE# high cycles after each read word (≥1).

- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin burst; sampled only in IDLE.
- is_write  in  1  mode, captured with start (1 = write, 0 = read).
- len  in  LEN_W  words in burst, captured with start; 0 = start ignored.
- abort  in  1  terminate burst at next edge.
- wr_data  in  DW  write word.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  block accepts wr_data this cycle.
- nand_dq_in  in  DW  DQ bus input.
- nand_dq_out  out  DW  DQ bus output value.
- nand_dq_oe  out  1  DQ output enable.
- strobe_n  out  1  WE# (write) or RE# (read), active low.
- rd_data  out  DW  captured read word.
- rd_valid  out  1  rd_data valid, one-cycle pulse, no backpressure.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal burst completion.

## Operation
- States: IDLE, LOAD (write only, await word), STROBE (strobe_n=0), HOLD (strobe_n=1), DONE.
- IDLE: start=1 and len≠0 → capture is_write, remaining=len; write → LOAD, read → STROBE (counter=T_REA). start with len=0 ignored.
- LOAD: wr_ready=1; on wr_valid → latch wr_data into nand_dq_out, oe=1, → STROBE (counter=T_WP).
- STROBE: strobe_n=0 for exactly T_WP/T_REA cycles, then → HOLD (counter=T_WH/T_REH). Read: nand_dq_in captured on the edge ending the last STROBE cycle.
- HOLD: strobe_n=1 for T_WH/T_REH cycles; remaining decremented on HOLD entry; at end → LOAD/STROBE if remaining≠0, else DONE.
- DONE: done=1, busy=1, one cycle, → IDLE.
- Write: nand_dq_oe=1 from LOAD acceptance through end of HOLD; 0 in LOAD waiting, IDLE, DONE and all read states; nand_dq_out holds last word otherwise.
- abort or reset in any state: next cycle IDLE, strobe_n=1, oe=0, wr_ready=0, no done, no rd_valid. abort in IDLE has no effect; reset also has priority over abort.
- start, is_write, len ignored while busy.

## Timing
- All outputs registered. Reset values: strobe_n=1, nand_dq_oe=0, nand_dq_out=0, rd_data=0, rd_valid=0, wr_ready=0, busy=0, done=0.
- start sampled at edge k → busy=1 and first state visible in cycle k+1.
- Write word with wr_valid already high: 1 LOAD + T_WP + T_WH cycles. Read word: T_REA + T_REH cycles.
- rd_valid pulses in first HOLD cycle of each read word.
- Burst of N words ends with one DONE cycle; busy falls the cycle after DONE; new start may be sampled in that IDLE cycle.
- wr_valid stall: block stays in LOAD indefinitely, strobe_n=1, oe=0.
- Counters: phase counter ≥ clog2(max T_*+1) bits; remaining counter LEN_W bits, never wraps (burst ends at 0).

## Structure
- Package nand_io_pkg: state enum, mode constants IO_READ/IO_WRITE, default timing constants shared with the command FSM.
- One sub-module natural: io_phase_timer (loadable down-counter, load value + expired flag), instantiated once.

## Test plan
- Write, DW=8, len=3, wr_valid constantly high, words 0xA1,0xB2,0xC3 → three strobe_n low pulses of 3 cycles, 2-cycle highs, dq_out matches each word while low, one done pulse, busy high 18+1 cycles.
- Read, len=2, nand_dq_in changing 0x55→0x66 between words → rd_valid twice, rd_data 0x55 then 0x66, each strobe_n low 4 cycles.
- Write, wr_valid dropped 5 cycles before second word → block holds in LOAD 5 extra cycles, strobe_n=1, oe=0, then completes normally.
- abort during second STROBE of len=4 read → next cycle IDLE, strobe_n=1, no done, only one rd_valid seen.
- reset asserted mid-HOLD of write → all outputs at reset values next cycle; start with len=0 afterwards → busy stays 0.
- start pulsed while busy with different len → ignored; original burst length preserved, DW=16 variant repeats scenario 1 with 16-bit words.

Source files
------------

// File: rtl/nand_io_burst_unit_pkg.sv
// nand_io_pkg: state encoding, mode constants and default NAND strobe timing shared with the command FSM
package nand_io_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic IO_READ  = 1'b0;
  localparam logic IO_WRITE = 1'b1;
  localparam int DEF_T_WP  = 3;
  localparam int DEF_T_WH  = 2;
  localparam int DEF_T_REA = 4;
  localparam int DEF_T_REH = 2;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = c > m ? c : m;
    return d > m ? d : m;
  endfunction
endpackage

// File: rtl/nand_io_burst_unit_io_phase_timer.sv
// io_phase_timer: loadable down-counter flagging the last cycle of a strobe phase
module io_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;
  // load on phase entry, then count down and rest at zero
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_expired = r_cnt <= W'(1);
endmodule

// File: rtl/nand_io_burst_unit.sv
// nand_io_burst_unit: moves a burst of words between the datapath and the NAND DQ bus with timed WE#/RE# strobes
module nand_io_burst_unit
  import nand_io_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LEN_W = 16,
  parameter int T_WP  = DEF_T_WP,
  parameter int T_WH  = DEF_T_WH,
  parameter int T_REA = DEF_T_REA,
  parameter int T_REH = DEF_T_REH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_write,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [DW-1:0]    wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    nand_dq_in,
  output logic [DW-1:0]    nand_dq_out,
  output logic             nand_dq_oe,
  output logic             strobe_n,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done
);
  localparam int TW = $clog2(max4(T_WP, T_WH, T_REA, T_REH) + 1);
  logic [2:0]       r_state;
  logic [2:0]       w_nxt;
  logic             r_mode;
  logic [LEN_W-1:0] r_rem;
  logic             w_exp;
  logic             w_abort;
  logic             w_wr;
  logic             w_load;
  logic             w_cap;
  logic [TW-1:0]    w_tval;
  io_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_val    (w_tval),
    .o_expired(w_exp)
  );
  assign w_abort = abort && r_state != S_IDLE;
  assign w_wr    = r_state == S_IDLE ? is_write : r_mode;
  assign w_load  = w_nxt != r_state;
  assign w_tval  = w_nxt == S_STROBE ? (w_wr ? TW'(T_WP) : TW'(T_REA))
                                     : (w_wr ? TW'(T_WH) : TW'(T_REH));
  assign w_cap   = r_state == S_STROBE && w_exp && r_mode == IO_READ && !w_abort;
  // next state; abort from any active state returns straight to idle
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && len != '0) w_nxt = is_write ? S_LOAD : S_STROBE;
      S_LOAD:   if (wr_valid) w_nxt = S_STROBE;
      S_STROBE: if (w_exp) w_nxt = S_HOLD;
      S_HOLD:   if (w_exp) w_nxt = r_rem != '0 ? (r_mode == IO_WRITE ? S_LOAD : S_STROBE) : S_DONE;
      default:  w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_IDLE;
  end
  // state, burst bookkeeping and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= IO_READ;
      r_rem       <= '0;
      nand_dq_out <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      strobe_n    <= 1'b1;
      nand_dq_oe  <= 1'b0;
      wr_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && w_nxt != S_IDLE) begin
        r_mode <= is_write;
        r_rem  <= len;
      end else if (r_state == S_STROBE && w_nxt == S_HOLD) r_rem <= r_rem - 1'b1;
      if (r_state == S_LOAD && w_nxt == S_STROBE) nand_dq_out <= wr_data;
      if (w_cap) rd_data <= nand_dq_in;
      rd_valid   <= w_cap;
      strobe_n   <= w_nxt != S_STROBE;
      nand_dq_oe <= r_mode == IO_WRITE && r_state != S_IDLE && (w_nxt == S_STROBE || w_nxt == S_HOLD);
      wr_ready   <= w_nxt == S_LOAD;
      busy       <= w_nxt != S_IDLE;
      done       <= w_nxt == S_DONE;
    end
  end
endmodule
